serial_result_capture: RTL and testbench



---
 rtl/serial_result_capture_pkg.sv | 14 +
 rtl/serial_result_capture_shift_in_reg.sv | 31 +++
 rtl/serial_result_capture.sv | 100 ++++++++++
 tb/tb_serial_result_capture.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_result_capture_pkg.sv
// Shared state encoding and counter sizing for the serial result capture block.
package serial_result_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CAPTURE = 2'b01,
    DONE    = 2'b10
  } state_e;

  function automatic int cntWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_result_capture_shift_in_reg.sv
// Serial-in shift register; the first bit received ends up at data[0] when LSB_FIRST=1.
module shift_in_reg
  import serial_result_capture_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] shift_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
    end else if (en) begin
      if (LSB_FIRST != 0) begin
        shift_q <= {din, shift_q[WIDTH-1:1]};
      end else begin
        shift_q <= {shift_q[WIDTH-2:0], din};
      end
    end
  end

  assign q = shift_q;

endmodule

// File: rtl/serial_result_capture.sv
// Collects WIDTH serial bits after a start pulse and presents them as a held parallel
// word with even parity and a one-cycle valid strobe.
module serial_result_capture
  import serial_result_capture_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       din,
  output logic [WIDTH-1:0]           data,
  output logic                       parity,
  output logic                       valid,
  output logic                       busy,
  output logic [cntWidth(WIDTH)-1:0] bit_cnt
);

  localparam int CW = cntWidth(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_e           state_q;
  logic [CW-1:0]    bitCnt_q;
  logic [WIDTH-1:0] data_q;
  logic             parity_q;
  logic             valid_q;
  logic             busy_q;
  logic [WIDTH-1:0] shiftWord;
  logic [WIDTH-1:0] word_d;
  logic             shiftEn;

  assign shiftEn = (state_q == CAPTURE);

  shift_in_reg #(
    .WIDTH    (WIDTH),
    .LSB_FIRST(LSB_FIRST)
  ) u_shift (
    .clk  (clk),
    .reset(reset),
    .en   (shiftEn),
    .din  (din),
    .q    (shiftWord)
  );

  // The result is latched on the same edge as the last shift, so it needs the post-shift word.
  always_comb begin
    word_d = shiftWord;
    if (LSB_FIRST != 0) begin
      word_d = {din, shiftWord[WIDTH-1:1]};
    end else begin
      word_d = {shiftWord[WIDTH-2:0], din};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      bitCnt_q <= '0;
      data_q   <= '0;
      parity_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q  <= CAPTURE;
            bitCnt_q <= '0;
            busy_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        CAPTURE: begin
          bitCnt_q <= bitCnt_q + CW'(1);
          if (bitCnt_q == LAST_IDX) begin
            state_q  <= DONE;
            data_q   <= word_d;
            parity_q <= ^word_d;
            valid_q  <= 1'b1;
            busy_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data    = data_q;
  assign parity  = parity_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign bit_cnt = bitCnt_q;

endmodule

// File: tb/tb_serial_result_capture.sv
// Scoreboard bench: drives one serial stream into an LSB-first and an MSB-first capture
// block and checks each completed word against a transaction-level model.
module tb_serial_result_capture;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] word;
    logic         par;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic din = 1'b0;

  logic [W-1:0] dataL, dataM;
  logic         parityL, parityM, validL, validM, busyL, busyM;
  logic [3:0]   cntL, cntM;

  exp_t qL[$];
  exp_t qM[$];
  logic [W-1:0] lastW[2];
  logic         lastP[2];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  bit  monEn = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_result_capture #(.WIDTH(W), .LSB_FIRST(1)) dutL (
    .clk(clk), .reset(reset), .start(start), .din(din),
    .data(dataL), .parity(parityL), .valid(validL), .busy(busyL), .bit_cnt(cntL)
  );

  serial_result_capture #(.WIDTH(W), .LSB_FIRST(0)) dutM (
    .clk(clk), .reset(reset), .start(start), .din(din),
    .data(dataM), .parity(parityM), .valid(validM), .busy(busyM), .bit_cnt(cntM)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compares one DUT against its expectation queue; s=0 is LSB-first, s=1 is MSB-first.
  task automatic monitorSide(input int s);
    exp_t e;
    int n;
    logic v, b, p;
    logic [W-1:0] d;
    logic [3:0] c;
    string tag;
    tag = (s == 0) ? "lsb" : "msb";
    if (s == 0) begin
      v = validL; b = busyL; p = parityL; d = dataL; c = cntL; n = qL.size();
    end else begin
      v = validM; b = busyM; p = parityM; d = dataM; c = cntM; n = qM.size();
    end
    checkOutput({tag, "_valid_busy_exclusive"}, int'(v & b), 0);
    if (v) begin
      if (n == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s_unexpected_valid: valid=1 with data %0h, expected no valid (cycle %0d)",
                 tag, d, cyc);
      end else begin
        if (s == 0) e = qL.pop_front(); else e = qM.pop_front();
        checkOutput({tag, "_data"}, d, e.word);
        checkOutput({tag, "_parity"}, p, e.par);
        checkOutput({tag, "_valid_cycle"}, cyc, e.due);
        checkOutput({tag, "_bitcnt_at_valid"}, c, W);
        lastW[s] = e.word;
        lastP[s] = e.par;
      end
    end else begin
      if (n > 0) begin
        if (s == 0) e = qL[0]; else e = qM[0];
        if (cyc > e.due) begin
          checkOutput({tag, "_missing_valid_cycle"}, cyc, e.due);
          if (s == 0) void'(qL.pop_front()); else void'(qM.pop_front());
        end
      end
      checkOutput({tag, "_data_hold"}, d, lastW[s]);
      checkOutput({tag, "_parity_hold"}, p, lastP[s]);
    end
  endtask

  always @(negedge clk) begin
    if (monEn) begin
      monitorSide(0);
      monitorSide(1);
    end
  end

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_lsb_data"}, dataL, 0);
    checkOutput({tag, "_lsb_parity"}, parityL, 0);
    checkOutput({tag, "_lsb_valid"}, validL, 0);
    checkOutput({tag, "_lsb_busy"}, busyL, 0);
    checkOutput({tag, "_lsb_bitcnt"}, cntL, 0);
    checkOutput({tag, "_msb_data"}, dataM, 0);
    checkOutput({tag, "_msb_parity"}, parityM, 0);
    checkOutput({tag, "_msb_valid"}, validM, 0);
    checkOutput({tag, "_msb_busy"}, busyM, 0);
    checkOutput({tag, "_msb_bitcnt"}, cntM, 0);
  endtask

  // stream[i] is the i-th bit received; lateAt/resetAt name the edge (1..W) for an
  // extra start pulse or a reset, 0 meaning none; keepStart leaves start high afterwards.
  task automatic applyStimulus(input logic [W-1:0] stream, input int lateAt,
                               input int resetAt, input bit keepStart);
    exp_t eL, eM;
    int ones;
    ones = 0;
    eL.word = '0;
    eM.word = '0;
    for (int i = 0; i < W; i++) begin
      eL.word[i] = stream[i];
      eM.word[W-1-i] = stream[i];
      ones += int'(stream[i]);
    end
    eL.par = logic'(ones % 2);
    eM.par = eL.par;
    eL.due = cyc + 1 + W;
    eM.due = eL.due;
    qL.push_back(eL);
    qM.push_back(eM);
    start = 1'b1;
    din = logic'($urandom_range(0, 1));
    @(posedge clk); #1;
    for (int i = 0; i < W; i++) begin
      checkOutput("lsb_busy_in_capture", busyL, 1);
      checkOutput("msb_busy_in_capture", busyM, 1);
      checkOutput("lsb_bitcnt_progress", cntL, i);
      checkOutput("msb_bitcnt_progress", cntM, i);
      din = stream[i];
      start = (i == lateAt - 1) ? 1'b1 : keepStart;
      reset = (i == resetAt - 1);
      @(posedge clk); #1;
      if (reset) begin
        reset = 1'b0;
        start = 1'b0;
        qL.delete(qL.size() - 1);
        qM.delete(qM.size() - 1);
        lastW[0] = '0; lastW[1] = '0;
        lastP[0] = 1'b0; lastP[1] = 1'b0;
        checkCleared("midreset");
        return;
      end
    end
    start = keepStart;
  endtask

  task automatic idleCycles(input int n);
    start = 1'b0;
    repeat (n) begin
      din = logic'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    lastW[0] = '0; lastW[1] = '0;
    lastP[0] = 1'b0; lastP[1] = 1'b0;
    reset = 1'b1;
    repeat (2) begin
      start = logic'($urandom_range(0, 1));
      din = logic'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    checkCleared("reset");
    reset = 1'b0;
    start = 1'b0;
    monEn = 1'b1;
    idleCycles(2);

    $display("[TB] directed captures");
    applyStimulus(8'h4D, 0, 0, 1'b0);
    idleCycles(2);
    applyStimulus(8'h07, 0, 0, 1'b0);
    idleCycles(1);
    applyStimulus(8'h4D, 3, 0, 1'b0);
    idleCycles(2);
    applyStimulus(8'h4D, 0, 4, 1'b0);
    idleCycles(2);
    applyStimulus(8'h07, 0, 0, 1'b0);
    idleCycles(3);
    applyStimulus(8'hFF, 0, 0, 1'b1);
    applyStimulus(8'h01, 0, 0, 1'b0);
    idleCycles(2);

    $display("[TB] random captures");
    for (int k = 0; k < 24; k++) begin
      logic [W-1:0] s;
      bit keep;
      int late, rst;
      s = W'($urandom);
      keep = (k != 23) && ($urandom_range(0, 3) == 0);
      late = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, W)) : 0;
      rst = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, W)) : 0;
      if (rst != 0) keep = 1'b0;
      applyStimulus(s, late, rst, keep);
      if (!keep) idleCycles(int'($urandom_range(0, 3)));
    end

    idleCycles(W + 4);
    checkOutput("lsb_queue_drained", qL.size(), 0);
    checkOutput("msb_queue_drained", qM.size(), 0);
    monEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
